uart_tx_drain: RTL and testbench
================================

// Module: uart_tx_drain
// PURPOSE
//  Serial transmitter sitting directly downstream of the team's 16x8 byte FIFO.
//  Pops one byte at a time (Ren pulse; data appears on the FIFO's registered Dout one
//  cycle later) and shifts it out as an 8N1/8N2 UART frame on txd, LSB first.
//  Sole reader of that FIFO.
// PARAMETERS
//  CLKS_PER_BIT  16  ck cycles per serial bit; legal range 2..65535
//  STOP_BITS     1   stop bits per frame; 1 or 2
// PORTS
//  ck       in   1  clock; all logic on posedge ck
//  rst      in   1  synchronous, active-high reset
//  Fempty   in   1  FIFO empty flag (registered in FIFO)
//  Fdata    in   8  FIFO Dout; valid the cycle after a Ren cycle with Fempty=0
//  Ren      out  1  FIFO read request; one-cycle pulse, decoded from state register
//  txd      out  1  serial line, idle high, registered
//  busy     out  1  1 whenever state != IDLE
//  tx_done  out  1  one-cycle pulse in last cycle of final stop bit
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, txd=1, Ren=0, busy=0, tx_done=0, counters=0.
//   Reset mid-frame aborts: txd=1 from the next edge, byte is lost, no tx_done.
//  FSM (one state per line, registered):
//   IDLE : txd=1. Fempty=0 -> REQ; else stay.
//   REQ  : Ren=1 (this cycle only). -> WAIT unconditionally (Fempty cannot rise
//          again before this pop, as this block is the only reader).
//   WAIT : Fdata valid; shreg<=Fdata, bitcnt<=0, baudcnt<=0. -> START.
//   START: txd=0 for CLKS_PER_BIT cycles. -> DATA.
//   DATA : txd=shreg[0]; on each bit end shreg>>=1, bitcnt++; after bit 7 -> STOP.
//   STOP : txd=1 for STOP_BITS*CLKS_PER_BIT cycles; tx_done=1 in last cycle -> IDLE.
//  Bit timing: baudcnt counts 0..CLKS_PER_BIT-1; bit end = (baudcnt==CLKS_PER_BIT-1),
//   then wraps to 0. Width $clog2(CLKS_PER_BIT). bitcnt 3 bits, stopcnt 1 bit.
//  Latency: Fempty seen low in IDLE at cycle n -> Ren high at n+1 -> txd falls at n+3.
//  Frame length: (9+STOP_BITS)*CLKS_PER_BIT cycles from first START cycle to last STOP.
//  Back-to-back: FIFO non-empty at STOP end gives exactly 3 idle-high cycles
//   (IDLE,REQ,WAIT) between stop bit and next start bit. No continuous-stream mode.
//  Fempty ignored outside IDLE; Fdata ignored outside WAIT.
//  Ren never asserted while Fempty=1 at the REQ entry decision; never two Ren
//   pulses per frame.
//  txd driven from a flop (no combinational glitch); Ren/busy decoded from state flops.
// STRUCTURE
//  Shared package uart_pkg: state encoding typedef (IDLE,REQ,WAIT,START,DATA,STOP, 3b),
//   UART_DATA_BITS=8, IDLE_LEVEL=1'b1. The uart_rx receiver uses the same package.
//  One sub-module: uart_baud_gen (counter with clear input and bit_end output,
//   parameter CLKS_PER_BIT). FSM, shift register and bit/stop counters stay at top.
// TESTING (CLKS_PER_BIT=4 unless noted; FIFO model = registered-Dout 16-deep FIFO)
//  1 Reset: rst=1 for 3 cycles with Fempty=0 -> txd=1, Ren=0, busy=0 throughout;
//    first Ren at 2nd edge after rst falls.
//  2 Single byte 0xA5: txd = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; Ren pulses
//    once; tx_done 1 cycle at cycle 40 of frame; Fempty=1 after -> IDLE, busy=0.
//  3 Back-to-back 0x00,0xFF preloaded: exactly 3 high cycles between 1st stop and
//    2nd start; two Ren pulses total; two tx_done pulses.
//  4 STOP_BITS=2, byte 0x80: stop phase 8 cycles; frame 44 cycles; tx_done at end.
//  5 Reset mid-frame (rst at DATA bit 3): txd=1 next edge, no tx_done; after release
//    next FIFO byte transmits cleanly from a START bit.
//  6 CLKS_PER_BIT=2, 16 bytes 0x00..0x0F filling FIFO: receiver model decodes all 16
//    in order; exactly 16 Ren pulses; no Ren while Fempty=1.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter (uart_tx_drain) and receiver
// (uart_rx): frame-sequencer state encoding, data width and line idle level.
// No ports; import with "import uart_pkg::*;".
// -----------------------------------------------------------------------------
package uart_pkg;

   // Number of data bits carried in one frame.
   localparam int unsigned UART_DATA_BITS = 8;

   // Level of the serial line when nothing is being sent (also the stop level).
   localparam logic IDLE_LEVEL = 1'b1;

   // Frame sequencer states, one serial phase per state.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      START = 3'd3,
      DATA  = 3'd4,
      STOP  = 3'd5
   } uart_state_e;

   // True in the states where the baud counter must run.
   function automatic logic uart_state_is_serial(input uart_state_e st);
      return (st == START) || (st == DATA) || (st == STOP);
   endfunction

endpackage : uart_pkg

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Bit-period counter. Counts 0..CLKS_PER_BIT-1 and flags the last clock of
// each serial bit; wraps to 0 after that clock. A synchronous clear holds the
// counter at 0 so the next bit period starts aligned to the clear release.
//
// Ports
//   i_clk      in  1  clock, rising edge
//   i_rst      in  1  synchronous active-high reset
//   i_clear    in  1  hold counter at 0 while high
//   o_bit_end  out 1  high during the last clock of a bit period
// -----------------------------------------------------------------------------
module uart_baud_gen #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clear,
   output logic o_bit_end
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] r_cnt;

   assign o_bit_end = (r_cnt == CNT_LAST);

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_cnt <= '0;
      end else if (o_bit_end) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule : uart_baud_gen

// File: rtl/uart_tx_drain.sv
// -----------------------------------------------------------------------------
// uart_tx_drain
// UART transmitter that drains a registered-output byte FIFO. Each frame pops
// exactly one byte and sends it LSB first as start + 8 data + STOP_BITS stop.
//
// FIFO handshake: Ren is a one-cycle pop request issued only from REQ, which
// is entered only from IDLE with Fempty low. The FIFO presents the popped byte
// on Fdata in the following cycle (WAIT), where it is captured. Fempty is only
// looked at in IDLE and Fdata only in WAIT. Being the sole reader, this block
// can rely on Fempty staying low between the IDLE decision and the pop.
//
// Parameters
//   CLKS_PER_BIT  clocks per serial bit (2..65535)
//   STOP_BITS     stop bits per frame (1 or 2)
//
// Ports
//   ck         in   1  clock, all logic on rising edge
//   rst        in   1  synchronous active-high reset; aborts a frame in flight
//   Fempty     in   1  FIFO empty flag
//   Fdata      in   8  FIFO registered data out
//   Ren        out  1  FIFO read pulse (state REQ)
//   txd        out  1  serial line, registered, idle high
//   busy       out  1  high whenever the sequencer is not in IDLE
//   tx_done    out  1  pulse in the last clock of the final stop bit
//   o_state    out  3  current sequencer state, for observation
// -----------------------------------------------------------------------------
module uart_tx_drain
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic        ck,
   input  logic        rst,
   input  logic        Fempty,
   input  logic [7:0]  Fdata,
   output logic        Ren,
   output logic        txd,
   output logic        busy,
   output logic        tx_done,
   output uart_state_e o_state
);

   localparam logic [2:0] BIT_LAST  = 3'(UART_DATA_BITS - 1);
   localparam logic       STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

   // Registered state
   uart_state_e r_state;
   logic [7:0]  r_shreg;
   logic [2:0]  r_bitcnt;
   logic        r_stopcnt;
   logic        r_txd;

   // Next-state values
   uart_state_e w_state_next;
   logic [7:0]  w_shreg_next;
   logic [2:0]  w_bitcnt_next;
   logic        w_stopcnt_next;
   logic        w_txd_next;
   logic        w_tx_done;

   logic        w_bit_end;
   logic        w_baud_clear;

   // The baud counter only runs during the serial phases; it sits at 0 in
   // IDLE/REQ/WAIT so the start bit is always a full bit period long.
   assign w_baud_clear = !uart_state_is_serial(r_state);

   uart_baud_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .i_clk     (ck),
      .i_rst     (rst),
      .i_clear   (w_baud_clear),
      .o_bit_end (w_bit_end)
   );

   // State register and datapath registers
   always_ff @(posedge ck) begin
      if (rst) begin
         r_state   <= IDLE;
         r_shreg   <= '0;
         r_bitcnt  <= '0;
         r_stopcnt <= 1'b0;
         r_txd     <= IDLE_LEVEL;
      end else begin
         r_state   <= w_state_next;
         r_shreg   <= w_shreg_next;
         r_bitcnt  <= w_bitcnt_next;
         r_stopcnt <= w_stopcnt_next;
         r_txd     <= w_txd_next;
      end
   end

   // Next-state, datapath update and tx_done decode
   always_comb begin
      w_state_next   = r_state;
      w_shreg_next   = r_shreg;
      w_bitcnt_next  = r_bitcnt;
      w_stopcnt_next = r_stopcnt;
      w_tx_done      = 1'b0;

      unique case (r_state)
         IDLE: begin
            if (!Fempty) begin
               w_state_next = REQ;
            end
         end

         REQ: begin
            w_state_next = WAIT;
         end

         WAIT: begin
            w_shreg_next   = Fdata;
            w_bitcnt_next  = '0;
            w_stopcnt_next = 1'b0;
            w_state_next   = START;
         end

         START: begin
            if (w_bit_end) begin
               w_state_next = DATA;
            end
         end

         DATA: begin
            if (w_bit_end) begin
               w_shreg_next  = {1'b0, r_shreg[7:1]};
               w_bitcnt_next = r_bitcnt + 3'd1;
               if (r_bitcnt == BIT_LAST) begin
                  w_state_next = STOP;
               end
            end
         end

         STOP: begin
            if (w_bit_end) begin
               if (r_stopcnt == STOP_LAST) begin
                  w_tx_done    = 1'b1;
                  w_state_next = IDLE;
               end else begin
                  w_stopcnt_next = r_stopcnt + 1'b1;
               end
            end
         end

         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // The line level is computed from the *next* state so that the flop output
   // changes on the same edge as the state register: txd is 0 in every START
   // cycle and shows shreg[0] in every DATA cycle, with no extra lag.
   always_comb begin
      w_txd_next = IDLE_LEVEL;
      if (w_state_next == START) begin
         w_txd_next = 1'b0;
      end else if (w_state_next == DATA) begin
         w_txd_next = w_shreg_next[0];
      end
   end

   assign txd     = r_txd;
   assign Ren     = (r_state == REQ);
   assign busy    = (r_state != IDLE);
   assign tx_done = w_tx_done;
   assign o_state = r_state;

endmodule : uart_tx_drain

// File: tb/tb_uart_tx_drain.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_drain
// Directed bench for uart_tx_drain. Three instances cover the parameter sets:
//   a: CLKS_PER_BIT=4, STOP_BITS=1   (reset, single byte, back-to-back, abort)
//   b: CLKS_PER_BIT=4, STOP_BITS=2   (two stop bits)
//   c: CLKS_PER_BIT=2, STOP_BITS=1   (16-byte drain decoded by a line receiver)
// Each instance reads its own 16-deep registered-output FIFO model.
// -----------------------------------------------------------------------------
module tb_uart_tx_drain;
   import uart_pkg::*;

   // ---------------- clock / reset ----------------
   logic ck = 1'b0;
   logic rst = 1'b1;
   always #5 ck = ~ck;

   // ---------------- DUT signals ----------------
   logic        ren_a, ren_b, ren_c;
   logic        txd_a, txd_b, txd_c;
   logic        busy_a, busy_b, busy_c;
   logic        done_a, done_b, done_c;
   uart_state_e st_a, st_b, st_c;
   logic [7:0]  fdata_v [3];
   logic [2:0]  fempty_v;
   logic [2:0]  ren_v, txd_v, busy_v, done_v;

   assign ren_v  = {ren_c, ren_b, ren_a};
   assign txd_v  = {txd_c, txd_b, txd_a};
   assign busy_v = {busy_c, busy_b, busy_a};
   assign done_v = {done_c, done_b, done_a};

   uart_tx_drain #(.CLKS_PER_BIT(4), .STOP_BITS(1)) u_a (
      .ck(ck), .rst(rst), .Fempty(fempty_v[0]), .Fdata(fdata_v[0]),
      .Ren(ren_a), .txd(txd_a), .busy(busy_a), .tx_done(done_a), .o_state(st_a));

   uart_tx_drain #(.CLKS_PER_BIT(4), .STOP_BITS(2)) u_b (
      .ck(ck), .rst(rst), .Fempty(fempty_v[1]), .Fdata(fdata_v[1]),
      .Ren(ren_b), .txd(txd_b), .busy(busy_b), .tx_done(done_b), .o_state(st_b));

   uart_tx_drain #(.CLKS_PER_BIT(2), .STOP_BITS(1)) u_c (
      .ck(ck), .rst(rst), .Fempty(fempty_v[2]), .Fdata(fdata_v[2]),
      .Ren(ren_c), .txd(txd_c), .busy(busy_c), .tx_done(done_c), .o_state(st_c));

   // ---------------- FIFO models + event counters ----------------
   logic [2:0] push_v = 3'b000;
   logic [7:0] push_data = 8'h00;
   logic [7:0] mem [3][16];
   logic [3:0] rp [3] = '{default: 4'd0};
   logic [3:0] wp [3] = '{default: 4'd0};
   int         cnt [3] = '{default: 0};
   int         ren_cnt [3] = '{default: 0};
   int         bad_ren [3] = '{default: 0};
   int         done_cnt [3] = '{default: 0};

   assign fempty_v = {cnt[2] == 0, cnt[1] == 0, cnt[0] == 0};

   always @(posedge ck) begin
      for (int g = 0; g < 3; g++) begin
         int pop;
         pop = 0;
         if (ren_v[g] === 1'b1) begin
            ren_cnt[g] <= ren_cnt[g] + 1;
            if (cnt[g] == 0) bad_ren[g] <= bad_ren[g] + 1;
            else begin
               pop = 1;
               fdata_v[g] <= mem[g][rp[g]];
               rp[g] <= rp[g] + 4'd1;
            end
         end
         if (push_v[g]) begin
            mem[g][wp[g]] <= push_data;
            wp[g] <= wp[g] + 4'd1;
         end
         cnt[g] <= cnt[g] + (push_v[g] ? 1 : 0) - pop;
         if (done_v[g] === 1'b1) done_cnt[g] <= done_cnt[g] + 1;
      end
   end

   // ---------------- line receiver for instance c (2 clocks per bit) ------
   // k counts clocks from the first start-bit clock (k=0); each bit is
   // sampled in its second clock.
   logic       rx_busy = 1'b0;
   int         rx_k = 0;
   logic [7:0] rx_sh = 8'h00;
   int         rx_ferr = 0;
   logic [7:0] rx_q[$];

   always @(negedge ck) begin
      if (!rx_busy) begin
         if (txd_c === 1'b0) begin
            rx_busy <= 1'b1;
            rx_k    <= 1;
         end
      end else begin
         rx_k <= rx_k + 1;
         if (rx_k >= 3 && rx_k <= 17 && (rx_k % 2) == 1) rx_sh[(rx_k - 3) / 2] <= txd_c;
         if (rx_k == 19) begin
            if (txd_c === 1'b1) rx_q.push_back(rx_sh);
            else rx_ferr <= rx_ferr + 1;
            rx_busy <= 1'b0;
         end
      end
   end

   // ---------------- scoreboard ----------------
   logic [7:0] exp_q[$];
   int n_checks = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic push(input int g, input logic [7:0] b);
      push_v[g] = 1'b1;
      push_data = b;
      @(negedge ck);
      push_v[g] = 1'b0;
   endtask

   // Advance negedge by negedge until txd of instance g is low; n returns the
   // number of high clocks seen first.
   task automatic wait_start(input int g, input int max, output int n);
      n = 0;
      while (txd_v[g] !== 1'b0 && n < max) begin
         @(negedge ck);
         n++;
      end
      chk("start_seen", {31'd0, txd_v[g]}, 32'd0);
   endtask

   // Called at the first START-cycle negedge; returns at the first cycle after
   // the frame.
   task automatic check_frame(input int g, input logic [7:0] b, input int cpb, input int sb);
      int last;
      int idx;
      logic e;
      last = (9 + sb) * cpb - 1;
      for (int c = 0; c <= last; c++) begin
         idx = c / cpb;
         if (idx == 0) e = 1'b0;
         else if (idx <= 8) e = b[idx - 1];
         else e = 1'b1;
         chk($sformatf("txd[%0d] c=%0d", g, c), {31'd0, txd_v[g]}, {31'd0, e});
         chk($sformatf("tx_done[%0d] c=%0d", g, c), {31'd0, done_v[g]}, (c == last) ? 32'd1 : 32'd0);
         chk($sformatf("busy[%0d] c=%0d", g, c), {31'd0, busy_v[g]}, 32'd1);
         @(negedge ck);
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      int r0;
      int d0;
      int guard;

      // 1: reset held 3 cycles with a byte already in the FIFO
      rst = 1'b1;
      push(0, 8'hA5);
      for (int i = 0; i < 3; i++) begin
         chk("t1_rst_txd", {31'd0, txd_a}, 32'd1);
         chk("t1_rst_ren", {31'd0, ren_a}, 32'd0);
         chk("t1_rst_busy", {31'd0, busy_a}, 32'd0);
         chk("t1_rst_done", {31'd0, done_a}, 32'd0);
         if (i < 2) @(negedge ck);
      end
      rst = 1'b0;
      @(negedge ck);
      chk("t1_first_ren", {31'd0, ren_a}, 32'd1);
      @(negedge ck);
      chk("t1_wait_ren", {31'd0, ren_a}, 32'd0);
      chk("t1_wait_txd", {31'd0, txd_a}, 32'd1);
      @(negedge ck);
      chk("t1_start_latency", {31'd0, txd_a}, 32'd0);

      // 2: single byte 0xA5
      check_frame(0, 8'hA5, 4, 1);
      chk("t2_idle_busy", {31'd0, busy_a}, 32'd0);
      chk("t2_idle_txd", {31'd0, txd_a}, 32'd1);
      chk("t2_idle_state", {29'd0, st_a}, {29'd0, IDLE});
      chk("t2_ren_count", ren_cnt[0], 32'd1);
      chk("t2_done_count", done_cnt[0], 32'd1);

      // 3: back-to-back 0x00, 0xFF
      r0 = ren_cnt[0];
      d0 = done_cnt[0];
      push(0, 8'h00);
      push(0, 8'hFF);
      wait_start(0, 20, n);
      check_frame(0, 8'h00, 4, 1);
      wait_start(0, 10, n);
      chk("t3_gap_cycles", n, 32'd3);
      check_frame(0, 8'hFF, 4, 1);
      chk("t3_ren_count", ren_cnt[0] - r0, 32'd2);
      chk("t3_done_count", done_cnt[0] - d0, 32'd2);

      // 5: reset in the middle of data bit 3 of 0x3C, then 0x5A goes out
      r0 = ren_cnt[0];
      d0 = done_cnt[0];
      push(0, 8'h3C);
      push(0, 8'h5A);
      wait_start(0, 20, n);
      repeat (16) @(negedge ck);
      chk("t5_bit3_level", {31'd0, txd_a}, 32'd1);
      rst = 1'b1;
      @(negedge ck);
      chk("t5_abort_txd", {31'd0, txd_a}, 32'd1);
      chk("t5_abort_busy", {31'd0, busy_a}, 32'd0);
      chk("t5_abort_done", {31'd0, done_a}, 32'd0);
      @(negedge ck);
      chk("t5_abort_txd2", {31'd0, txd_a}, 32'd1);
      rst = 1'b0;
      wait_start(0, 10, n);
      chk("t5_restart_gap", n, 32'd3);
      check_frame(0, 8'h5A, 4, 1);
      chk("t5_done_count", done_cnt[0] - d0, 32'd1);
      chk("t5_ren_count", ren_cnt[0] - r0, 32'd2);

      // 4: two stop bits, byte 0x80, 44-cycle frame
      push(1, 8'h80);
      wait_start(1, 20, n);
      check_frame(1, 8'h80, 4, 2);
      chk("t4_done_count", done_cnt[1], 32'd1);
      chk("t4_idle_busy", {31'd0, busy_b}, 32'd0);

      // 6: 16 bytes through the 2-clock-per-bit instance
      for (int i = 0; i < 16; i++) begin
         exp_q.push_back(8'(i));
         push(2, 8'(i));
      end
      guard = 0;
      while (done_cnt[2] < 16 && guard < 2000) begin
         @(negedge ck);
         guard++;
      end
      chk("t6_done_count", done_cnt[2], 32'd16);
      chk("t6_rx_count", rx_q.size(), 32'd16);
      chk("t6_frame_errors", rx_ferr, 32'd0);
      for (int i = 0; i < 16; i++) begin
         logic [7:0] e;
         e = exp_q.pop_front();
         chk($sformatf("t6_byte%0d", i), (i < rx_q.size()) ? {24'd0, rx_q[i]} : 32'hDEAD, {24'd0, e});
      end
      chk("t6_ren_count", ren_cnt[2], 32'd16);
      chk("bad_ren_total", bad_ren[0] + bad_ren[1] + bad_ren[2], 32'd0);
      chk("t6_idle_busy", {31'd0, busy_c}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule : tb_uart_tx_drain
